// File: rtl/route_allocator_pkg.sv
// Shared NoC definitions for the route allocator.
//   port_state_e : per-output reservation state (FREE / LOCKED)
//   DIR_*        : switch port direction indices
//   rr_next      : round-robin successor of an index modulo n
package route_allocator_pkg;

  typedef enum logic {
    PORT_FREE   = 1'b0,
    PORT_LOCKED = 1'b1
  } port_state_e;

  localparam int unsigned DIR_NORTH = 0;
  localparam int unsigned DIR_SOUTH = 1;
  localparam int unsigned DIR_WEST  = 2;
  localparam int unsigned DIR_EAST  = 3;

  // Next pointer position after index idx, wrapping n-1 to 0.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/route_allocator_arb.sv
// Round-robin arbiter for one switch output.
// Picks the first asserted request at or after ptr, wrapping N-1 to 0.
//   req   : N-bit request vector
//   ptr   : priority pointer (highest-priority index)
//   gnt_c : one-hot grant (all zero when no request), combinational
//   idx_c : index of the granted request (0 when none), combinational
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] idx_c
);

  logic          found;
  logic [IW-1:0] cand;

  // Scan candidates in priority order starting at ptr.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        gnt_c[cand] = 1'b1;
        idx_c       = cand;
      end
    end
  end

endmodule

// File: rtl/route_allocator.sv
// Route allocator for an N-port switch: reserves one output per input
// with per-output round-robin arbitration.
//   clk, rst  : clock (rising edge), synchronous active-high reset
//   req_valid : per-input route-reserve request
//   req_port  : per-input requested output index (REQUEST_WIDTH each)
//   release_i : per-input tail-flit release ("release" is a reserved word)
//   grant     : one-cycle reservation pulse per input
//   sel       : per-output index of the owning input (0 while free)
//   out_busy  : per-output reserved flag
//   in_locked : per-input "owns an output" flag
module route_allocator
  import route_allocator_pkg::*;
#(
  parameter int unsigned N             = 4,
  parameter int unsigned REQUEST_WIDTH = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               req_valid,
  input  logic [N*REQUEST_WIDTH-1:0] req_port,
  input  logic [N-1:0]               release_i,
  output logic [N-1:0]               grant,
  output logic [N*$clog2(N)-1:0]     sel,
  output logic [N-1:0]               out_busy,
  output logic [N-1:0]               in_locked
);

  localparam int unsigned SW = $clog2(N);

  port_state_e   state_q [N];
  port_state_e   state_d [N];
  logic [SW-1:0] owner_q [N];
  logic [SW-1:0] owner_d [N];
  logic [SW-1:0] ptr_q   [N];
  logic [SW-1:0] ptr_d   [N];
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  in_locked_q, in_locked_d;

  logic [N-1:0]  arb_req [N];
  logic [N-1:0]  arb_gnt [N];
  logic [SW-1:0] arb_idx [N];

  // Eligible requesters per output; a locked output sees no requests.
  always_comb begin
    for (int unsigned o = 0; o < N; o++) begin
      arb_req[o] = '0;
      for (int unsigned i = 0; i < N; i++) begin
        arb_req[o][i] = (state_q[o] == PORT_FREE) && req_valid[i] && !in_locked_q[i] &&
                        (req_port[i*REQUEST_WIDTH +: REQUEST_WIDTH] == REQUEST_WIDTH'(o));
      end
    end
  end

  for (genvar o = 0; o < N; o++) begin : g_arb
    rr_arbiter #(.N(N), .IW(SW)) u_arb (
      .req   (arb_req[o]),
      .ptr   (ptr_q[o]),
      .gnt_c (arb_gnt[o]),
      .idx_c (arb_idx[o])
    );
  end

  // Release frees a locked output; otherwise a free output takes its arbiter winner.
  // A release only clears state this cycle, so regrant can happen one cycle later.
  always_comb begin
    grant_d     = '0;
    in_locked_d = in_locked_q;
    for (int unsigned o = 0; o < N; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      if (state_q[o] == PORT_LOCKED) begin
        if (release_i[owner_q[o]]) begin
          state_d[o]                = PORT_FREE;
          owner_d[o]                = '0;
          in_locked_d[owner_q[o]]   = 1'b0;
        end
      end else if (|arb_gnt[o]) begin
        state_d[o]  = PORT_LOCKED;
        owner_d[o]  = arb_idx[o];
        ptr_d[o]    = SW'(rr_next(32'(arb_idx[o]), N));
        grant_d     = grant_d | arb_gnt[o];
        in_locked_d = in_locked_d | arb_gnt[o];
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q     <= '0;
      in_locked_q <= '0;
      for (int unsigned o = 0; o < N; o++) begin
        state_q[o] <= PORT_FREE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      grant_q     <= grant_d;
      in_locked_q <= in_locked_d;
      for (int unsigned o = 0; o < N; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

  // Owner is held at 0 while free, so sel decodes straight from the flops.
  for (genvar o = 0; o < N; o++) begin : g_out
    assign sel[o*SW +: SW] = owner_q[o];
    assign out_busy[o]     = (state_q[o] == PORT_LOCKED);
  end

  assign grant     = grant_q;
  assign in_locked = in_locked_q;

endmodule

// File: tb/tb_route_allocator.sv
// Directed self-checking bench for route_allocator (N=4).
module tb_route_allocator;

  localparam int unsigned N  = 4;
  localparam int unsigned RW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*RW-1:0] req_port;
  logic [N-1:0]   release_i;
  logic [N-1:0]   grant;
  logic [N*2-1:0] sel;
  logic [N-1:0]   out_busy;
  logic [N-1:0]   in_locked;

  int n_cmp = 0;
  int n_err = 0;

  route_allocator #(.N(N), .REQUEST_WIDTH(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_port  (req_port),
    .release_i (release_i),
    .grant     (grant),
    .sel       (sel),
    .out_busy  (out_busy),
    .in_locked (in_locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic [7:0] s,
                           input logic [3:0] b, input logic [3:0] l);
    check({tag, ".grant"},     32'(grant),     32'(g));
    check({tag, ".sel"},       32'(sel),       32'(s));
    check({tag, ".out_busy"},  32'(out_busy),  32'(b));
    check({tag, ".in_locked"}, 32'(in_locked), 32'(l));
  endtask

  logic [3:0] exp_order [5];

  initial begin
    exp_order[0] = 4'd0; exp_order[1] = 4'd1; exp_order[2] = 4'd2;
    exp_order[3] = 4'd3; exp_order[4] = 4'd0;

    rst = 1'b1; req_valid = '0; req_port = '0; release_i = '0;
    tick(); tick();
    rst = 1'b0;
    check_all("reset", 4'b0000, 8'h00, 4'b0000, 4'b0000);

    // Single request: input 1 -> port 2.
    req_valid = 4'b0010; req_port = 8'h08;
    tick();
    check_all("single", 4'b0010, 8'h10, 4'b0100, 4'b0010);
    tick();
    check_all("single_hold", 4'b0000, 8'h10, 4'b0100, 4'b0010);
    req_valid = '0; release_i = 4'b0010;
    tick();
    check_all("single_rel", 4'b0000, 8'h00, 4'b0000, 4'b0000);
    release_i = '0;

    // Inputs 0 and 3 contend for port 1; input 3 wins two cycles after release.
    req_valid = 4'b1001; req_port = 8'h41;
    tick();
    check_all("cont_win0", 4'b0001, 8'h00, 4'b0010, 4'b0001);
    req_valid = 4'b1000; release_i = 4'b0001;
    tick();
    check_all("cont_free", 4'b0000, 8'h00, 4'b0000, 4'b0000);
    release_i = '0;
    tick();
    check_all("cont_win3", 4'b1000, 8'h0C, 4'b0010, 4'b1000);
    req_valid = '0; release_i = 4'b1000;
    tick();
    check_all("cont_rel", 4'b0000, 8'h00, 4'b0000, 4'b0000);
    release_i = '0;

    // Permutation: all four granted in one cycle.
    req_valid = 4'b1111; req_port = 8'h1B;
    tick();
    check_all("perm", 4'b1111, 8'h1B, 4'b1111, 4'b1111);
    req_valid = '0; release_i = 4'b1111;
    tick();
    check_all("perm_rel", 4'b0000, 8'h00, 4'b0000, 4'b0000);
    release_i = '0;

    // All contend for port 0, winner releases the cycle after its grant.
    req_valid = 4'b1111; req_port = 8'h00;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("rr%0d.grant", k), 32'(grant), 32'(4'b0001 << exp_order[k]));
      check($sformatf("rr%0d.sel", k), 32'(sel), 32'(exp_order[k]));
      release_i = grant;
      tick();
      check($sformatf("rr%0d.free", k), 32'(out_busy), 32'd0);
      release_i = '0;
    end
    req_valid = '0;
    tick();
    check_all("rr_idle", 4'b0000, 8'h00, 4'b0000, 4'b0000);

    // Stray release from an unlocked input changes nothing.
    req_valid = 4'b0010; req_port = 8'h0C;
    tick();
    check_all("stray_lock", 4'b0010, 8'h40, 4'b1000, 4'b0010);
    req_valid = '0; release_i = 4'b0100;
    tick();
    check_all("stray_rel", 4'b0000, 8'h40, 4'b1000, 4'b0010);
    release_i = 4'b0010;
    tick();
    release_i = '0;
    check_all("stray_clr", 4'b0000, 8'h00, 4'b0000, 4'b0000);

    // Reset while ports 0 and 2 are locked, with request and release pending.
    req_valid = 4'b1001; req_port = 8'h80;
    tick();
    check_all("pre_rst", 4'b1001, 8'h30, 4'b0101, 4'b1001);
    rst = 1'b1; release_i = 4'b0001; req_valid = 4'b0110; req_port = 8'h34;
    tick();
    check_all("mid_rst", 4'b0000, 8'h00, 4'b0000, 4'b0000);
    rst = 1'b0; release_i = '0; req_valid = 4'b0010; req_port = 8'h04;
    tick();
    check_all("post_rst", 4'b0010, 8'h04, 4'b0010, 4'b0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/route_allocator.md
ROUTE_ALLOCATOR -- requirements
Module: route_allocator

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of switch ports (inputs = outputs).
REQ-002 SHALL have parameter REQUEST_WIDTH, default $clog2(N), meaning width of a requested output-port index.
REQ-003 SHALL have port clk  input  1  clock; rising edge only.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  N  bit i = input i holds a route-reserve request.
REQ-006 SHALL have port req_port  input  N*REQUEST_WIDTH  slice i = output port requested by input i.
REQ-007 SHALL have port release  input  N  bit i = input i has forwarded its tail flit and frees its path.
REQ-008 SHALL have port grant  output  N  bit i = one-cycle route-reserve-status pulse to input i.
REQ-009 SHALL have port sel  output  N*$clog2(N)  slice o = index of the input driving output o.
REQ-010 SHALL have port out_busy  output  N  bit o = output o is reserved.
REQ-011 SHALL have port in_locked  output  N  bit i = input i owns an output.

Function
REQ-012 SHALL keep per-output state FREE or LOCKED, plus owner index and round-robin pointer.
REQ-013 SHALL treat input i as eligible for output o when req_valid[i]=1, req_port slice i = o, and in_locked[i]=0.
REQ-014 SHALL, for a FREE output with at least one eligible input, select the first eligible input at or after the output's pointer, wrapping N-1 to 0.
REQ-015 SHALL register each grant: request sampled in cycle t gives grant pulse, LOCKED state, owner, sel and in_locked all visible in cycle t+1.
REQ-016 SHALL hold grant[i] high for exactly one cycle per reservation, even if req_valid[i] stays high.
REQ-017 SHALL set the output's pointer to (owner+1) mod N on grant.
REQ-018 SHALL ignore req_valid from locked inputs and leave losing requesters waiting, with no grant and no error.
REQ-019 SHALL, on release[i] while input i owns output o, return o to FREE and clear in_locked[i] in the next cycle.
REQ-020 SHALL make a released output grantable no earlier than the cycle after it reads FREE; there is no same-cycle release and regrant.
REQ-021 SHALL ignore release[i] when input i owns no output.
REQ-022 SHALL drive sel slice o = owner while LOCKED and 0 while FREE.
REQ-023 SHALL allow requests to different outputs to be granted in the same cycle, and shall allow an input to request its own port index.
REQ-024 SHALL grant at most one input per output and at most one output per input.

Reset
REQ-025 SHALL, on rst=1 at a clock edge (including mid-packet), set all outputs FREE, all pointers 0, and grant, sel, out_busy and in_locked to 0.
REQ-026 SHALL take rst precedence over simultaneous request and release.

Structure
REQ-027 SHALL take the FREE/LOCKED state encoding and the port direction constants (0 North, 1 South, 2 West, 3 East) from the shared NoC package.
REQ-028 SHALL build each output's arbiter from one sub-module, rr_arbiter (N-bit request vector and pointer in; one-hot grant and index out), instantiated N times in a generate loop.

Verification
REQ-029 SHALL pass: N=4, input 1 requests port 2 at cycle 0 -> grant=0010, sel[2]=1, out_busy=0100 at cycle 1, grant=0 at cycle 2.
REQ-030 SHALL pass: inputs 0 and 3 request port 1 with pointer 0 -> input 0 granted; after release[0], input 3 is granted 2 cycles after release.
REQ-031 SHALL pass: inputs 0-3 request ports 3, 2, 1, 0 simultaneously -> grant=1111 in one cycle, sel={0,1,2,3} for outputs 3..0.
REQ-032 SHALL pass: all four inputs contend for port 0 with each winner releasing one cycle after grant -> grant order 0, 1, 2, 3, 0.
REQ-033 SHALL pass: release[2] while input 2 is unlocked -> no state change.
REQ-034 SHALL pass: rst asserted while ports 0 and 2 are LOCKED -> all outputs 0 next cycle, then a fresh request is granted 1 cycle after rst drops.
